// File: rtl/stego_extract_ctrl.sv
// LSB-steganography extraction controller: walks a byte-wide image RAM, rebuilds each message
// byte from 8 consecutive LSBs and streams it out over valid/ready.
module stego_extract_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              term_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_count
);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StEmit, StFin} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              term_q, term_d;
  logic              done_q, done_d;
  logic              hs;
  logic              last_byte;
  logic [LEN_W-1:0]  cnt_inc;

  assign hs        = (state_q == StEmit) && out_ready;
  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign last_byte = (cnt_inc == len_q) || (term_q && (shift_q == 8'h00));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition outside idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (msg_len == '0) ? StFin : StFetch;
      StFetch: if (bit_q == 3'd7) state_d = StDrain;
      StDrain: state_d = StEmit;
      StEmit:  if (hs) state_d = last_byte ? StFin : StFetch;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  // Datapath: read pointer, bit index, shift register, latched transfer parameters
  always_comb begin
    ptr_d   = ptr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    len_d   = len_q;
    term_d  = term_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d  = base_addr;
          len_d  = msg_len;
          term_d = term_en;
          cnt_d  = '0;
          bit_d  = '0;
        end
      end
      StFetch: begin
        ptr_d = ptr_q + ADDR_W'(1);
        bit_d = bit_q + 3'd1;
        // RAM data lags the address by one cycle, so this cycle's LSB belongs to bit k-1
        if (bit_q != 3'd0) shift_d[bit_q - 3'd1] = mem_rdata[0];
      end
      StDrain: shift_d[7] = mem_rdata[0];
      StEmit:  if (hs) cnt_d = cnt_inc;
      default: ;
    endcase
    done_d = (state_q == StFin) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      term_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      term_q  <= term_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs
  always_comb begin
    mem_rd_en  = (state_q == StFetch);
    mem_addr   = ptr_q;
    out_valid  = (state_q == StEmit);
    out_byte   = shift_q;
    busy       = (state_q != StIdle);
    done       = done_q;
    byte_count = cnt_q;
  end

endmodule

// File: tb/tb_stego_extract_ctrl.sv
// Directed bench for stego_extract_ctrl with a behavioural image RAM and a negedge monitor.
module tb_stego_extract_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [7:0]  msg_len;
  logic        term_en;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [7:0]  byte_count;

  logic [7:0]  ram [0:65535];

  int errors = 0;
  int checks = 0;

  logic [15:0] addr_q [$];
  logic [7:0]  byte_q [$];
  int          done_cnt;
  int          done_at;
  int          first_valid;
  int          idx;
  logic        mon_en = 1'b0;

  stego_extract_ctrl #(.ADDR_W(16), .LEN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .msg_len    (msg_len),
    .term_en    (term_en),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  // Index n corresponds to the cycle following edge En after the start edge E0
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd_en) addr_q.push_back(mem_addr);
      if (out_valid && out_ready) byte_q.push_back(out_byte);
      if (out_valid && first_valid < 0) first_valid = idx;
      if (done) begin
        done_cnt++;
        done_at = idx;
      end
      idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_byte(input logic [15:0] a, input logic [7:0] b);
    for (int k = 0; k < 8; k++) ram[a + 16'(k)] = {7'h53, b[k]};
  endtask

  task automatic go(input logic [15:0] b, input logic [7:0] l, input logic t);
    @(posedge clk);
    #1;
    base_addr = b;
    msg_len   = l;
    term_en   = t;
    start     = 1'b1;
    @(posedge clk);
    addr_q.delete();
    byte_q.delete();
    done_cnt    = 0;
    done_at     = -1;
    first_valid = -1;
    idx         = 0;
    mon_en      = 1'b1;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int bad;
    logic [15:0] e;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; term_en = 1'b0;
    base_addr = '0; msg_len = '0; out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[0] = 8'h01; ram[2] = 8'h01;
    #12;
    check("rst_outputs", {31'd0, mem_rd_en | out_valid | busy | done}, 32'd0);
    check("rst_data", {8'd0, mem_addr, out_byte} | {24'd0, byte_count}, 32'd0);
    rst_n = 1'b1;

    // Single byte, latency reference
    go(16'h0000, 8'd1, 1'b0);
    wait_done("t1", 40);
    check("t1_nbytes", byte_q.size(), 1);
    check("t1_byte", byte_q.size() > 0 ? byte_q[0] : 8'hxx, 8'h05);
    check("t1_valid_at", first_valid, 9);
    check("t1_done_at", done_at, 11);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_count", byte_count, 8'd1);
    check("t1_nreads", addr_q.size(), 8);
    check("t1_idle", busy, 1'b0);

    // "Hi" at 0x0010
    put_byte(16'h0010, 8'h48);
    put_byte(16'h0018, 8'h69);
    go(16'h0010, 8'd2, 1'b0);
    wait_done("t2", 60);
    check("t2_nbytes", byte_q.size(), 2);
    check("t2_byte0", byte_q.size() > 0 ? byte_q[0] : 8'hxx, 8'h48);
    check("t2_byte1", byte_q.size() > 1 ? byte_q[1] : 8'hxx, 8'h69);
    check("t2_nreads", addr_q.size(), 16);
    bad = 0;
    foreach (addr_q[i]) begin
      e = 16'h0010 + 16'(i);
      if (addr_q[i] !== e) bad++;
    end
    check("t2_addr_seq", bad, 0);
    check("t2_count", byte_count, 8'd2);
    check("t2_done_cnt", done_cnt, 1);

    // Terminator stops a long transfer
    put_byte(16'h0100, 8'h41);
    put_byte(16'h0108, 8'h00);
    put_byte(16'h0110, 8'h42);
    go(16'h0100, 8'd200, 1'b1);
    wait_done("t3", 60);
    check("t3_nbytes", byte_q.size(), 2);
    check("t3_byte0", byte_q.size() > 0 ? byte_q[0] : 8'hxx, 8'h41);
    check("t3_byte1", byte_q.size() > 1 ? byte_q[1] : 8'hxx, 8'h00);
    check("t3_count", byte_count, 8'd2);
    check("t3_nreads", addr_q.size(), 16);
    check("t3_last_addr", addr_q.size() > 0 ? addr_q[addr_q.size() - 1] : 16'hxxxx, 16'h010F);
    check("t3_done_cnt", done_cnt, 1);

    // Sink stall with an ignored start
    put_byte(16'h0200, 8'h5A);
    put_byte(16'h0208, 8'h3C);
    out_ready = 1'b0;
    go(16'h0200, 8'd2, 1'b0);
    wait_valid("t4", 20);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || out_byte !== 8'h5A || mem_rd_en) bad++;
      if (i == 2) begin
        base_addr = 16'h0300;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #2;
    end
    start = 1'b0;
    check("t4_stall_stable", bad, 0);
    out_ready = 1'b1;
    wait_done("t4", 60);
    check("t4_nbytes", byte_q.size(), 2);
    check("t4_byte0", byte_q.size() > 0 ? byte_q[0] : 8'hxx, 8'h5A);
    check("t4_byte1", byte_q.size() > 1 ? byte_q[1] : 8'hxx, 8'h3C);
    check("t4_addr8", addr_q.size() > 8 ? addr_q[8] : 16'hxxxx, 16'h0208);
    check("t4_nreads", addr_q.size(), 16);

    // Address wrap
    put_byte(16'hFFFC, 8'hC3);
    go(16'hFFFC, 8'd1, 1'b0);
    wait_done("t5", 40);
    bad = 0;
    foreach (addr_q[i]) begin
      e = 16'hFFFC + 16'(i);
      if (addr_q[i] !== e) bad++;
    end
    check("t5_addr_seq", bad, 0);
    check("t5_nreads", addr_q.size(), 8);
    check("t5_byte", byte_q.size() > 0 ? byte_q[0] : 8'hxx, 8'hC3);

    // Zero length
    go(16'h0010, 8'd0, 1'b0);
    wait_done("t6", 10);
    check("t6_nreads", addr_q.size(), 0);
    check("t6_no_valid", first_valid, -1);
    check("t6_done_at", done_at, 1);
    check("t6_count", byte_count, 8'd0);

    // Abort in fetch
    go(16'h0010, 8'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("t7_busy", busy, 1'b0);
    check("t7_rd_en", mem_rd_en, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    check("t7_no_done", done_cnt, 0);
    check("t7_count", byte_count, 8'd0);

    // Abort coincident with a handshake
    out_ready = 1'b0;
    go(16'h0010, 8'd2, 1'b0);
    wait_valid("t8", 20);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("t8_busy", busy, 1'b0);
    check("t8_count", byte_count, 8'd1);
    repeat (4) @(posedge clk);
    #2;
    check("t8_no_done", done_cnt, 0);

    // Reset mid-emit
    out_ready = 1'b0;
    go(16'h0010, 8'd2, 1'b0);
    wait_valid("t9", 20);
    #1 rst_n = 1'b0;
    #1;
    check("t9_rst_ctrl", {31'd0, mem_rd_en | out_valid | busy | done}, 32'd0);
    check("t9_rst_data", {8'd0, mem_addr, out_byte} | {24'd0, byte_count}, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    mon_en    = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
